aidan_mcnay_divrem_unit: RTL and testbench

Parametrised iterative unsigned divider producing quotient, remainder and a divide-by-zero flag for each opa/opb pair, behind a latency-insensitive val/rdy interface. Restoring division, one quotient bit per cycle, with fixed worst-case latency and early exits for trivial cases. Drop-in successor for the shift divider in the prime-detection datapath: the remainder feeds the divisibility check directly, so no separate modulo step is needed.

---
 rtl/aidan_mcnay_divrem_unit_if.sv | 9 +
 rtl/aidan_mcnay_divrem_unit.sv | 65 ++++++
 tb/tb_aidan_mcnay_divrem_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/aidan_mcnay_divrem_unit_if.sv
// aidan_mcnay_divrem_unit_if: val/rdy operand and result bundle for the divider
interface aidan_mcnay_divrem_unit_if #(parameter int nbits = 16);
  logic [nbits-1:0] opa, opb, quotient, remainder;
  logic istream_val, istream_rdy, div_by_zero, ostream_val, ostream_rdy;
  modport master(output opa, opb, istream_val, ostream_rdy,
                 input istream_rdy, quotient, remainder, div_by_zero, ostream_val);
  modport slave(input opa, opb, istream_val, ostream_rdy,
                output istream_rdy, quotient, remainder, div_by_zero, ostream_val);
endinterface

// File: rtl/aidan_mcnay_divrem_unit.sv
// aidan_mcnay_divrem_unit: iterative restoring unsigned divider with quotient, remainder and divide-by-zero flag
module aidan_mcnay_divrem_unit #(parameter int nbits = 16) (
  input logic clk,
  input logic reset,
  aidan_mcnay_divrem_unit_if.slave io
);
  localparam int cw = $clog2(nbits + 1);
  localparam logic [1:0] idle = 2'd0, calc = 2'd1, done = 2'd2;
  logic [1:0] state_q, state_d;
  logic [nbits-1:0] d_q, d_d, q_q, q_d, r_q, r_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic [nbits:0] t;
  logic ge, acc, zero, early;
  always_comb begin
    t = {r_q, q_q[nbits-1]};
    ge = t >= {1'b0, d_q};
    acc = state_q == idle && io.istream_val && !reset;
    zero = io.opb == '0;
    early = zero || io.opa < io.opb;
    state_d = state_q;
    d_d = d_q;
    q_d = q_q;
    r_d = r_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (acc) begin
      state_d = early ? done : calc;
      d_d = io.opb;
      q_d = zero ? '1 : early ? '0 : io.opa;
      r_d = early ? io.opa : '0;
      cnt_d = cw'(nbits);
      dbz_d = zero;
    end else if (state_q == calc) begin
      state_d = cnt_q == cw'(1) ? done : calc;
      q_d = {q_q[nbits-2:0], ge};
      r_d = ge ? nbits'(t - {1'b0, d_q}) : t[nbits-1:0];
      cnt_d = cnt_q - cw'(1);
    end else if (state_q == done && io.ostream_rdy) begin
      state_d = idle;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= idle;
      d_q <= '0;
      q_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q <= d_d;
      q_q <= q_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end
  assign io.istream_rdy = state_q == idle && !reset;
  assign io.ostream_val = state_q == done;
  assign io.quotient = q_q;
  assign io.remainder = r_q;
  assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_aidan_mcnay_divrem_unit.sv
// tb_aidan_mcnay_divrem_unit: vector, corner-case and randomized checks of the divider
module tb_aidan_mcnay_divrem_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  aidan_mcnay_divrem_unit_if #(.nbits(16)) i16();
  aidan_mcnay_divrem_unit_if #(.nbits(8)) i8();
  aidan_mcnay_divrem_unit #(.nbits(16)) dut16 (.clk(clk), .reset(reset), .io(i16.slave));
  aidan_mcnay_divrem_unit #(.nbits(8)) dut8 (.clk(clk), .reset(reset), .io(i8.slave));
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [15:0] a, b, q, r;
    logic z;
    int lat, hold;
  } vec_t;
  vec_t tv[9];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic sample(input bit w8, output logic [15:0] q, output logic [15:0] r,
                        output logic z, output logic ov, output logic ir);
    q = w8 ? {8'h0, i8.quotient} : i16.quotient;
    r = w8 ? {8'h0, i8.remainder} : i16.remainder;
    z = w8 ? i8.div_by_zero : i16.div_by_zero;
    ov = w8 ? i8.ostream_val : i16.ostream_val;
    ir = w8 ? i8.istream_rdy : i16.istream_rdy;
  endtask
  task automatic xact(input bit w8, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eq, input logic [15:0] er, input logic ez,
                      input int elat, input int hold);
    int n;
    logic [15:0] q, r;
    logic z, ov, ir;
    n = 0;
    sample(w8, q, r, z, ov, ir);
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
      sample(w8, q, r, z, ov, ir);
    end
    chk("istream_rdy_wait", {31'b0, ir}, 32'd1);
    if (w8) begin
      i8.opa = a[7:0];
      i8.opb = b[7:0];
      i8.istream_val = 1'b1;
    end else begin
      i16.opa = a;
      i16.opb = b;
      i16.istream_val = 1'b1;
    end
    @(negedge clk);
    i8.istream_val = 1'b0;
    i16.istream_val = 1'b0;
    n = 1;
    sample(w8, q, r, z, ov, ir);
    while (!ov && n < 40) begin
      @(negedge clk);
      n++;
      sample(w8, q, r, z, ov, ir);
    end
    chk("latency", n, elat);
    chk("quotient", {16'b0, q}, {16'b0, eq});
    chk("remainder", {16'b0, r}, {16'b0, er});
    chk("div_by_zero", {31'b0, z}, {31'b0, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      sample(w8, q, r, z, ov, ir);
      chk("hold_quotient", {16'b0, q}, {16'b0, eq});
      chk("hold_remainder", {16'b0, r}, {16'b0, er});
      chk("hold_ostream_val", {31'b0, ov}, 32'd1);
      chk("hold_istream_rdy", {31'b0, ir}, 32'd0);
    end
    i8.ostream_rdy = w8;
    i16.ostream_rdy = !w8;
    @(negedge clk);
    i8.ostream_rdy = 1'b0;
    i16.ostream_rdy = 1'b0;
    sample(w8, q, r, z, ov, ir);
    chk("post_consume_ostream_val", {31'b0, ov}, 32'd0);
    chk("post_consume_istream_rdy", {31'b0, ir}, 32'd1);
  endtask
  task automatic model(input bit w8, input logic [15:0] a, input logic [15:0] b, input int hold);
    int nb, ai, bi;
    nb = w8 ? 8 : 16;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) xact(w8, a, b, 16'((1 << nb) - 1), a, 1'b1, 1, hold);
    else xact(w8, a, b, 16'(ai / bi), 16'(ai % bi), 1'b0, ai < bi ? 1 : nb + 1, hold);
  endtask
  initial begin
    logic seen;
    i16.opa = '0; i16.opb = '0; i16.istream_val = 1'b0; i16.ostream_rdy = 1'b0;
    i8.opa = '0; i8.opb = '0; i8.istream_val = 1'b0; i8.ostream_rdy = 1'b0;
    tv[0] = '{16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 0};
    tv[1] = '{16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1, 0};
    tv[2] = '{16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, 0};
    tv[3] = '{16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1, 0};
    tv[4] = '{16'd10, 16'd3, 16'd3, 16'd1, 1'b0, 17, 0};
    tv[5] = '{16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 17, 5};
    tv[6] = '{16'd7, 16'd7, 16'd1, 16'd0, 1'b0, 17, 0};
    tv[7] = '{16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1, 0};
    tv[8] = '{16'hFFFF, 16'hFFFE, 16'd1, 16'd1, 1'b0, 17, 2};
    repeat (3) @(negedge clk);
    chk("reset_istream_rdy", {31'b0, i16.istream_rdy}, 32'd0);
    chk("reset_ostream_val", {31'b0, i16.ostream_val}, 32'd0);
    chk("reset_quotient", {16'b0, i16.quotient}, 32'd0);
    reset = 1'b0;
    #1;
    chk("after_reset_istream_rdy", {31'b0, i16.istream_rdy}, 32'd1);
    for (int i = 0; i < 9; i++) xact(1'b0, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].z, tv[i].lat, tv[i].hold);
    @(negedge clk);
    i16.opa = 16'd65535;
    i16.opb = 16'd255;
    i16.istream_val = 1'b1;
    @(negedge clk);
    i16.istream_val = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_calc_reset_istream_rdy", {31'b0, i16.istream_rdy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_calc_post_istream_rdy", {31'b0, i16.istream_rdy}, 32'd1);
    chk("mid_calc_post_quotient", {16'b0, i16.quotient}, 32'd0);
    chk("mid_calc_post_remainder", {16'b0, i16.remainder}, 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= i16.ostream_val;
    end
    chk("mid_calc_no_result", {31'b0, seen}, 32'd0);
    xact(1'b0, 16'd49, 16'd7, 16'd7, 16'd0, 1'b0, 17, 0);
    xact(1'b1, 16'd255, 16'd16, 16'd15, 16'd15, 1'b0, 9, 1);
    for (int i = 0; i < 1000; i++) begin
      int s;
      logic [15:0] b;
      s = $urandom_range(0, 9);
      b = s < 1 ? 16'd0 : s < 5 ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 255));
      model(1'b1, 16'($urandom_range(0, 255)), b, $urandom_range(0, 2));
    end
    for (int i = 0; i < 200; i++) begin
      int s;
      logic [15:0] b;
      s = $urandom_range(0, 9);
      b = s < 1 ? 16'd0 : s < 5 ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      model(1'b0, 16'($urandom_range(0, 65535)), b, $urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
